// File: rtl/tuner_sequencer.sv
// Frame sequencer for the tuner pipeline: capture -> FFT -> peak search over one shared sample RAM,
// with a per-phase watchdog, single-shot/continuous operation and one published peak bin per frame.
module tuner_sequencer #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 10,
    parameter int BIN_W          = 10,
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int HOLDOFF_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              err_clear,
    output logic              cap_go,
    input  logic              cap_done,
    input  logic              cap_we,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_wdata,
    output logic              fft_go,
    input  logic              fft_done,
    input  logic              fft_we,
    input  logic [ADDR_W-1:0] fft_addr,
    input  logic [DATA_W-1:0] fft_wdata,
    output logic              pk_go,
    input  logic              pk_done,
    input  logic [ADDR_W-1:0] pk_addr,
    input  logic [BIN_W-1:0]  pk_bin,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BIN_W-1:0]  result_bin,
    output logic              result_valid,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_phase
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    localparam int HO_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HO_W-1:0] HO_LAST = HO_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_FFT,
        S_PEAK,
        S_PUBLISH,
        S_HOLDOFF,
        S_ERROR
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd_cnt;
    logic [HO_W-1:0] ho_cnt;
    logic            wd_expired;

    assign wd_expired = (wd_cnt == WD_LAST);
    assign busy       = (state != S_IDLE) && (state != S_ERROR);
    assign err        = (state == S_ERROR);

    // Done is tested before the watchdog so a done on the last allowed cycle still advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            wd_cnt       <= '0;
            ho_cnt       <= '0;
            cap_go       <= 1'b0;
            fft_go       <= 1'b0;
            pk_go        <= 1'b0;
            result_valid <= 1'b0;
            result_bin   <= '0;
            err_phase    <= 2'd0;
        end else begin
            cap_go       <= 1'b0;
            fft_go       <= 1'b0;
            pk_go        <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start || continuous) begin
                        state  <= S_CAPTURE;
                        cap_go <= 1'b1;
                        wd_cnt <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (cap_done) begin
                        state  <= S_FFT;
                        fft_go <= 1'b1;
                        wd_cnt <= '0;
                    end else if (wd_expired) begin
                        state     <= S_ERROR;
                        err_phase <= 2'd1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                S_FFT: begin
                    if (fft_done) begin
                        state  <= S_PEAK;
                        pk_go  <= 1'b1;
                        wd_cnt <= '0;
                    end else if (wd_expired) begin
                        state     <= S_ERROR;
                        err_phase <= 2'd2;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                S_PEAK: begin
                    if (pk_done) begin
                        state        <= S_PUBLISH;
                        result_bin   <= pk_bin;
                        result_valid <= 1'b1;
                    end else if (wd_expired) begin
                        state     <= S_ERROR;
                        err_phase <= 2'd3;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                S_PUBLISH: begin
                    if (continuous) begin
                        state  <= S_HOLDOFF;
                        ho_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_HOLDOFF: begin
                    if (!continuous) begin
                        state <= S_IDLE;
                    end else if (ho_cnt == HO_LAST) begin
                        state  <= S_CAPTURE;
                        cap_go <= 1'b1;
                        wd_cnt <= '0;
                    end else begin
                        ho_cnt <= ho_cnt + HO_W'(1);
                    end
                end
                S_ERROR: begin
                    if (err_clear) begin
                        state     <= S_IDLE;
                        err_phase <= 2'd0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM port mux; gated by rst so a write is cut in the very cycle reset is asserted.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            case (state)
                S_CAPTURE: begin
                    mem_we    = cap_we;
                    mem_addr  = cap_addr;
                    mem_wdata = cap_wdata;
                end
                S_FFT: begin
                    mem_we    = fft_we;
                    mem_addr  = fft_addr;
                    mem_wdata = fft_wdata;
                end
                S_PEAK: begin
                    mem_addr = pk_addr;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tuner_sequencer.sv
// Bench for tuner_sequencer: delay-programmable phase blocks, random RAM traffic and a timeline model
// that predicts go/done/publish/error cycles and RAM ownership from the phase delays.
module tb_tuner_sequencer;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 10;
    localparam int BIN_W  = 10;
    localparam int TO     = 64;
    localparam int HO     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic              err_clear = 1'b0;
    logic              cap_go, fft_go, pk_go;
    logic              cap_done, fft_done, pk_done;
    logic              cap_we = 1'b0, fft_we = 1'b0;
    logic [ADDR_W-1:0] cap_addr = '0, fft_addr = '0, pk_addr = '0;
    logic [DATA_W-1:0] cap_wdata = '0, fft_wdata = '0;
    logic [BIN_W-1:0]  pk_bin;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BIN_W-1:0]  result_bin;
    logic              result_valid, busy, err;
    logic [1:0]        err_phase;

    tuner_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BIN_W(BIN_W),
        .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .err_clear(err_clear),
        .cap_go(cap_go), .cap_done(cap_done), .cap_we(cap_we), .cap_addr(cap_addr), .cap_wdata(cap_wdata),
        .fft_go(fft_go), .fft_done(fft_done), .fft_we(fft_we), .fft_addr(fft_addr), .fft_wdata(fft_wdata),
        .pk_go(pk_go), .pk_done(pk_done), .pk_addr(pk_addr), .pk_bin(pk_bin),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .result_bin(result_bin), .result_valid(result_valid),
        .busy(busy), .err(err), .err_phase(err_phase)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Phase blocks: done pulses dly cycles after their go; dly 0 means the block never finishes.
    int               cap_dly = 0, fft_dly = 0, pk_dly = 0;
    int               cap_cnt = 0, fft_cnt = 0, pk_cnt = 0;
    logic             cap_done_m = 1'b0, fft_done_m = 1'b0, pk_done_m = 1'b0, pk_done_x = 1'b0;
    logic [BIN_W-1:0] pk_bin_val = '0;

    assign cap_done = cap_done_m;
    assign fft_done = fft_done_m;
    assign pk_done  = pk_done_m | pk_done_x;
    assign pk_bin   = pk_bin_val;

    always @(negedge clk) begin
        cap_done_m = 1'b0;
        fft_done_m = 1'b0;
        pk_done_m  = 1'b0;
        if (rst) begin
            cap_cnt = 0;
            fft_cnt = 0;
            pk_cnt  = 0;
        end else begin
            if (cap_cnt > 0) begin cap_cnt--; if (cap_cnt == 0) cap_done_m = 1'b1; end
            if (fft_cnt > 0) begin fft_cnt--; if (fft_cnt == 0) fft_done_m = 1'b1; end
            if (pk_cnt > 0)  begin pk_cnt--;  if (pk_cnt == 0)  pk_done_m  = 1'b1; end
            if (cap_go) cap_cnt = cap_dly;
            if (fft_go) fft_cnt = fft_dly;
            if (pk_go)  pk_cnt  = pk_dly;
        end
    end

    int cap_go_n = 0, fft_go_n = 0, pk_go_n = 0, rv_n = 0;
    int cap_go_t = 0, fft_go_t = 0, pk_go_t = 0;
    always @(negedge clk) begin
        if (cap_go)       begin cap_go_n++; cap_go_t = cyc; end
        if (fft_go)       begin fft_go_n++; fft_go_t = cyc; end
        if (pk_go)        begin pk_go_n++;  pk_go_t  = cyc; end
        if (result_valid) rv_n++;
    end

    int               n_checks = 0;
    int               n_pass = 0;
    logic [BIN_W-1:0] last_bin = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        start     = 1'b0;
        err_clear = 1'b0;
        pk_done_x = 1'b0;
        cap_we    = 1'($urandom_range(0, 1));
        cap_addr  = ADDR_W'($urandom);
        cap_wdata = DATA_W'($urandom);
        fft_we    = 1'($urandom_range(0, 1));
        fft_addr  = ADDR_W'($urandom);
        fft_wdata = DATA_W'($urandom);
        pk_addr   = ADDR_W'($urandom);
        #1;
    endtask

    // Owner of the RAM port at cycle t, given the predicted phase boundaries.
    function automatic logic [31:0] exp_mux(input int t, input int c, input int e1, input int e2, input int e3);
        if (t >= c && t < e1)  return {10'd0, cap_we, cap_addr, cap_wdata};
        if (t >= e1 && t < e2) return {10'd0, fft_we, fft_addr, fft_wdata};
        if (t >= e2 && t < e3) return {10'd0, 1'b0, pk_addr, {DATA_W{1'b0}}};
        return '0;
    endfunction

    function automatic int pick();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 0;
        if (r == 1) return TO - 1;
        return int'($urandom_range(1, 30));
    endfunction

    // Runs one frame whose cap_go is expected in cycle c; a phase with delay 0 or >= TO times out.
    task automatic run_frame(input int c, input int dc, input int df, input int dp,
                             input logic [BIN_W-1:0] bin, input bit spur, input bit cont);
        int e1, e2, e3;
        bit ok1, ok2, ok3, exp_busy;
        int n_cap, n_fft, n_pk, n_rv;
        cap_dly = dc; fft_dly = df; pk_dly = dp; pk_bin_val = bin;
        n_cap = cap_go_n; n_fft = fft_go_n; n_pk = pk_go_n; n_rv = rv_n;
        ok1 = (dc > 0) && (dc < TO);
        e1  = c + (ok1 ? dc + 1 : TO);
        ok2 = ok1 && (df > 0) && (df < TO);
        e2  = ok1 ? e1 + (ok2 ? df + 1 : TO) : e1;
        ok3 = ok2 && (dp > 0) && (dp < TO);
        e3  = ok2 ? e2 + (ok3 ? dp + 1 : TO) : e2;
        while (cyc < e3) begin
            step();
            check("mem_mux", {10'd0, mem_we, mem_addr, mem_wdata}, exp_mux(cyc, c, e1, e2, e3));
            exp_busy = cont || (cyc >= c && (cyc < e3 || ok3));
            check("busy", 32'(busy), 32'(exp_busy));
            if (spur && cyc == c + 1) pk_done_x = 1'b1;
            if (cyc == c + 2) start = 1'b1;
        end
        check("cap_go_t", cap_go_t, c);
        check("cap_go_n", cap_go_n - n_cap, 1);
        check("fft_go_n", fft_go_n - n_fft, 32'(ok1));
        if (ok1) check("fft_go_t", fft_go_t, e1);
        check("pk_go_n", pk_go_n - n_pk, 32'(ok2));
        if (ok2) check("pk_go_t", pk_go_t, e2);
        if (ok3) begin
            check("result_valid", 32'(result_valid), 1);
            check("result_bin", 32'(result_bin), 32'(bin));
            check("rv_n", rv_n - n_rv, 1);
            last_bin = bin;
            if (!cont) begin
                step();
                check("idle_busy", 32'(busy), 0);
                check("rv_pulse", 32'(result_valid), 0);
            end
        end else begin
            check("err", 32'(err), 1);
            check("err_phase", 32'(err_phase), !ok1 ? 1 : (!ok2 ? 2 : 3));
            check("err_busy", 32'(busy), 0);
            cap_we = 1'b1; fft_we = 1'b1; #1;
            check("err_mem_we", 32'(mem_we), 0);
            start = 1'b1;
            step();
            check("err_hold", 32'(err), 1);
            check("err_start_ign", cap_go_n - n_cap, 1);
            err_clear = 1'b1;
            step();
            check("err_clr", 32'(err), 0);
            check("err_phase_clr", 32'(err_phase), 0);
            check("err_clr_busy", 32'(busy), 0);
            check("err_bin_kept", 32'(result_bin), 32'(last_bin));
        end
    endtask

    task automatic single(input int dc, input int df, input int dp, input logic [BIN_W-1:0] bin, input bit spur);
        step();
        start = 1'b1;
        run_frame(cyc + 1, dc, df, dp, bin, spur, 1'b0);
    endtask

    initial begin
        int c, s, n;
        repeat (3) step();
        check("rst_outs", {19'd0, cap_go, fft_go, pk_go, mem_we, result_valid, busy, err, err_phase, 2'd0},
              32'd0);
        check("rst_bin", 32'(result_bin), 0);
        check("rst_mem", {10'd0, mem_we, mem_addr, mem_wdata}, 0);
        rst = 1'b0;
        step();
        check("idle_busy0", 32'(busy), 0);

        single(10, 20, 5, 10'd37, 1'b0);
        single(20, 8, 6, 10'd55, 1'b1);
        single(TO - 1, 3, 3, 10'd200, 1'b0);
        single(TO, 3, 3, 10'd201, 1'b0);
        single(5, 0, 5, 10'd11, 1'b0);
        single(3, 4, 0, 10'd12, 1'b0);

        step();
        continuous = 1'b1;
        c = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            run_frame(c, int'($urandom_range(1, 20)), int'($urandom_range(1, 20)),
                      int'($urandom_range(1, 20)), BIN_W'(100 + i), 1'b0, 1'b1);
            c = cyc + HO + 1;
        end
        step();
        step();
        continuous = 1'b0;
        step();
        check("cont_drop_idle", 32'(busy), 0);
        n = cap_go_n;
        repeat (8) step();
        check("cont_no_restart", cap_go_n, n);

        step();
        cap_dly = 3; fft_dly = 40; pk_dly = 5;
        start = 1'b1;
        s = cyc;
        while (cyc < s + 8) step();
        fft_we = 1'b1; #1;
        check("fft_owns_we", 32'(mem_we), 1);
        rst = 1'b1; #1;
        check("rst_cuts_we", 32'(mem_we), 0);
        step();
        rst = 1'b0; #1;
        check("rst_mid_outs", {19'd0, cap_go, fft_go, pk_go, mem_we, result_valid, busy, err, err_phase, 2'd0},
              32'd0);
        check("rst_mid_bin", 32'(result_bin), 0);
        last_bin = '0;
        single(7, 9, 4, 10'd321, 1'b0);

        for (int i = 0; i < 8; i++) begin
            single(pick(), pick(), pick(), BIN_W'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
